vram_sdp_fill: RTL

- Parametrised single-clock simple dual-port video RAM.
- Write port: CPU side, with per-byte-lane enables. Read port: display scanout side, with a selectable output pipeline register.
- Built-in fill engine clears or fills the whole array with a constant value, one word per cycle.
- Replaces the fixed 4096x8 dual-clock VRAM macro wherever the CPU and display share one clock domain.

---
 rtl/vram_sdp_fill.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vram_sdp_fill.sv
// ---------------------------------------------------------------------------
// vram_sdp_fill
//
// Single-clock simple dual-port video RAM with a built-in fill engine.
//   - Write port (CPU side) has per-byte-lane enables. It is stalled through
//     wr_ready while the fill engine owns the array.
//   - Read port (display scanout side) is fully pipelined. Read latency is
//     1 cycle, or 2 cycles when OUT_REG=1.
//   - Fill engine writes one constant word per cycle across the whole array.
//
// Same-cycle read/write collisions are read-first by default. Defining
// VRAM_WR_BYPASS_EN makes them write-first:
//   - read vs CPU write returns the merged word;
//   - read vs fill returns the fill word.
//
// Parameters:
//   DW      data width in bits (multiple of 8)
//   AW      address width, depth = 2**AW words
//   OUT_REG 0: read latency 1, 1: extra output register, read latency 2
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   wr_en      write request, taken only while wr_ready=1
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte-lane enables, bit i covers wr_data[8i+7:8i]
//   wr_ready   write accepted; low while the fill engine is active
//   rd_en      read request, always accepted
//   rd_addr    read address
//   rd_data    read data; holds its last value when no read completes
//   rd_valid   rd_data valid this cycle
//   fill_start single-cycle fill request, honoured only when idle
//   fill_value fill word, captured when fill_start is accepted
//   fill_busy  fill engine active
//   fill_done  one-cycle pulse after the last word is written
// ---------------------------------------------------------------------------
module vram_sdp_fill #(
  parameter int DW      = 8,
  parameter int AW      = 12,
  parameter int OUT_REG = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  output logic            wr_ready,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  input  logic            fill_start,
  input  logic [DW-1:0]   fill_value,
  output logic            fill_busy,
  output logic            fill_done
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   fill_addr;
  logic [DW-1:0]   fill_word;
  logic            fill_we;
  logic            cpu_we;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   s1_data;
  logic            s1_valid;

  // -------------------------------------------------------------------------
  // Fill FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values. The read-first collision behaviour relies on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Fill FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fill_start) state_nxt = S_FILL;
      // Leave on the terminal count. The counter never wraps while in FILL.
      S_FILL:  if (fill_addr == '1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Fill FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    fill_busy = (state == S_FILL);
    fill_done = (state == S_DONE);
    wr_ready  = (state != S_FILL);
    fill_we   = (state == S_FILL);
  end

  // A CPU write in the fill-accepting cycle still lands, because wr_ready is
  // still high in that cycle.
  assign cpu_we = wr_en & wr_ready;

  // -------------------------------------------------------------------------
  // Fill address counter and captured fill word
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_addr <= '0;
      fill_word <= '0;
    end else if (state == S_IDLE && fill_start) begin
      fill_addr <= '0;
      fill_word <= fill_value;
    end else if (state == S_FILL) begin
      fill_addr <= fill_addr + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset, so it maps onto block RAM. After a reset
  // its contents are whatever was last written, including a partial fill.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= fill_word;
    end else if (cpu_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read word selection
  // -------------------------------------------------------------------------
`ifdef VRAM_WR_BYPASS_EN
  // Write-first. Forward this cycle's write into a read of the same address.
  // The fill engine and a CPU write are never active in the same cycle.
  always_comb begin
    rd_word = mem[rd_addr];
    if (fill_we && fill_addr == rd_addr) begin
      rd_word = fill_word;
    end else if (cpu_we && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end
`else
  // Read-first. The array read sees the pre-write word.
  always_comb begin
    rd_word = mem[rd_addr];
  end
`endif

  // -------------------------------------------------------------------------
  // Read pipeline, stage 1. Data is captured only on a read, so rd_data
  // holds its last value between reads.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
    end
  end

  // -------------------------------------------------------------------------
  // Optional output register, stage 2
  // -------------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_no_out_reg
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule
